// File: rtl/ramp_ctrl_pkg.sv
// Shared types, default parameters and Gray helper for the ramp ADC conversion controller.
package ramp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_CNT = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_CONVERT   = 3'd3,
        ST_READOUT   = 3'd4
    } state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_RST_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    function automatic logic [31:0] gray_enc(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/ramp_conversion_ctrl_timer.sv
// Loadable down-counter timing the RESET_CNT, SETTLE and CONVERT phases.
module ramp_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/ramp_conversion_ctrl.sv
// Ramp ADC conversion sequencer: counter clear, ramp settle, Gray-count ramp, readout handshake.
// Optional abort input and logic are built only when CONV_ABORT_EN is defined.
//
// state        | meaning
// ST_IDLE      | waiting for start; done pulses here for one cycle after readout
// ST_RESET_CNT | column latches cleared for RST_CYCLES cycles
// ST_SETTLE    | ramp settling for SETTLE_CYCLES cycles, ramp disabled
// ST_CONVERT   | ramp running, Gray count broadcast for 2^WIDTH cycles
// ST_READOUT   | final code held, data_valid until read_ack
module ramp_conversion_ctrl
    import ramp_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             read_ack,
`ifdef CONV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             cnt_reset,
    output logic             ramp_en,
    output logic [WIDTH-1:0] gray_code,
    output logic             data_valid,
    output logic             done
);

    localparam int RW  = $clog2(RST_CYCLES + 1);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TW0 = (WIDTH > RW) ? WIDTH : RW;
    localparam int TW  = (TW0 > SW) ? TW0 : SW;

    localparam logic [TW-1:0] LD_RST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] LD_CONV   = TW'((1 << WIDTH) - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             w_dec;
    logic [TW-1:0]    w_count;
    logic             w_tc;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] r_gray;
    logic             r_busy;
    logic             r_cnt_reset;
    logic             r_ramp_en;
    logic             r_data_valid;
    logic             r_done;

    ramp_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    // CONVERT loads the timer with all-ones, so the binary count is its complement.
    assign w_bin_next = ~WIDTH'(w_count - TW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        w_gray_nxt  = r_gray;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gray_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_RESET_CNT;
                    w_load      = 1'b1;
                    w_load_val  = LD_RST;
                end
            end
            ST_RESET_CNT: begin
                w_gray_nxt = '0;
                if (w_tc) begin
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                    w_load_val  = LD_SETTLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                w_gray_nxt = '0;
                if (w_tc) begin
                    w_state_nxt = ST_CONVERT;
                    w_load      = 1'b1;
                    w_load_val  = LD_CONV;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_CONVERT: begin
                if (w_tc) begin
                    w_state_nxt = ST_READOUT;
                end else begin
                    w_dec      = 1'b1;
                    w_gray_nxt = WIDTH'(gray_enc(32'(w_bin_next)));
                end
            end
            ST_READOUT: begin
                if (read_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_gray_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gray_nxt  = '0;
            end
        endcase
`ifdef CONV_ABORT_EN
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
            w_dec       = 1'b0;
            w_gray_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gray       <= '0;
            r_busy       <= 1'b0;
            r_cnt_reset  <= 1'b0;
            r_ramp_en    <= 1'b0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gray       <= w_gray_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_cnt_reset  <= (w_state_nxt == ST_RESET_CNT);
            r_ramp_en    <= (w_state_nxt == ST_CONVERT);
            r_data_valid <= (w_state_nxt == ST_READOUT);
            r_done       <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign cnt_reset  = r_cnt_reset;
    assign ramp_en    = r_ramp_en;
    assign gray_code  = r_gray;
    assign data_valid = r_data_valid;
    assign done       = r_done;

endmodule
